// File: rtl/vending_machine_param.sv
// Parametrised coin-operated vending controller: accumulates credit, vends at PRICE_UNITS,
// returns excess or cancelled credit as serial change_5 pulses, and tracks item stock.
module vending_machine_param #(
   parameter int PRICE_UNITS = 3,
   parameter int C1_UNITS    = 1,
   parameter int C2_UNITS    = 2,
   parameter int C3_UNITS    = 5,
   parameter int CREDIT_W    = 4,
   parameter int STOCK_W     = 4,
   parameter int STOCK_INIT  = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          coin,
   input  logic                cancel,
   input  logic                restock,
   output logic                newspaper,
   output logic                change_5,
   output logic                coin_reject,
   output logic                sold_out,
   output logic                busy,
   output logic [CREDIT_W-1:0] credit,
   output logic [STOCK_W-1:0]  stock
);

   localparam logic [1:0] S_ACCEPT = 2'd0;
   localparam logic [1:0] S_VEND   = 2'd1;
   localparam logic [1:0] S_RETURN = 2'd2;

   localparam logic [CREDIT_W-1:0] PRICE      = CREDIT_W'(PRICE_UNITS);
   localparam logic [STOCK_W-1:0]  STOCK_LOAD = STOCK_W'(STOCK_INIT);

   logic [1:0]          r_state;
   logic [CREDIT_W-1:0] r_credit;
   logic [STOCK_W-1:0]  r_stock;
   logic                r_coin_reject;

   logic [CREDIT_W-1:0] w_coin_val;
   logic [CREDIT_W-1:0] w_sum;
   logic [CREDIT_W-1:0] w_after_vend;
   logic                w_sold_out;

   always_comb begin
      w_coin_val = '0;
      case (coin)
         2'b01:   w_coin_val = CREDIT_W'(C1_UNITS);
         2'b10:   w_coin_val = CREDIT_W'(C2_UNITS);
         2'b11:   w_coin_val = CREDIT_W'(C3_UNITS);
         default: w_coin_val = '0;
      endcase
   end

   assign w_sum        = r_credit + w_coin_val;
   assign w_after_vend = r_credit - PRICE;
   assign w_sold_out   = (r_stock == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_ACCEPT;
         r_credit      <= '0;
         r_stock       <= STOCK_LOAD;
         r_coin_reject <= 1'b0;
      end else begin
         r_coin_reject <= 1'b0;
         case (r_state)
            S_ACCEPT: begin
               if (cancel) begin
                  if (r_credit != '0) r_state <= S_RETURN;
                  if (coin != 2'b00)  r_coin_reject <= 1'b1;
               end else if (coin != 2'b00) begin
                  if (w_sold_out) begin
                     r_coin_reject <= 1'b1;
                  end else begin
                     r_credit <= w_sum;
                     if (w_sum >= PRICE) r_state <= S_VEND;
                  end
               end
            end
            S_VEND: begin
               r_credit <= w_after_vend;
               if (!w_sold_out)    r_stock <= r_stock - 1'b1;
               if (coin != 2'b00)  r_coin_reject <= 1'b1;
               r_state <= (w_after_vend != '0) ? S_RETURN : S_ACCEPT;
            end
            S_RETURN: begin
               if (coin != 2'b00) r_coin_reject <= 1'b1;
               if (r_credit != '0) r_credit <= r_credit - 1'b1;
               if (r_credit <= 1)  r_state <= S_ACCEPT;
            end
            default: r_state <= S_ACCEPT;
         endcase
         // Restock is evaluated last so it wins over a decrement in the same cycle.
         if (restock) r_stock <= STOCK_LOAD;
      end
   end

   assign newspaper   = (r_state == S_VEND);
   assign change_5    = (r_state == S_RETURN);
   assign busy        = (r_state != S_ACCEPT);
   assign coin_reject = r_coin_reject;
   assign sold_out    = w_sold_out;
   assign credit      = r_credit;
   assign stock       = r_stock;

endmodule
